// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: operand write port, start/status and array edge streams of systolic_feeder
//   wr_en_i/wr_sel_i/wr_addr_i/wr_data_i : operand write (sel 0=A 1=B, addr {row,col})
//   start_i : launch feed; busy_o/done_o/array_clr_no : status and array clear
//   left_o_0..3 / up_o_0..3 : skewed row/column streams to the array edges
interface systolic_feeder_if #(parameter int DATA_W = 32);
  logic              wr_en_i;
  logic              wr_sel_i;
  logic [3:0]        wr_addr_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              start_i;
  logic              busy_o;
  logic              array_clr_no;
  logic              done_o;
  logic [DATA_W-1:0] left_o_0, left_o_1, left_o_2, left_o_3;
  logic [DATA_W-1:0] up_o_0, up_o_1, up_o_2, up_o_3;
  modport master (
    output wr_en_i, wr_sel_i, wr_addr_i, wr_data_i, start_i,
    input  busy_o, array_clr_no, done_o,
    input  left_o_0, left_o_1, left_o_2, left_o_3, up_o_0, up_o_1, up_o_2, up_o_3
  );
  modport slave (
    input  wr_en_i, wr_sel_i, wr_addr_i, wr_data_i, start_i,
    output busy_o, array_clr_no, done_o,
    output left_o_0, left_o_1, left_o_2, left_o_3, up_o_0, up_o_1, up_o_2, up_o_3
  );
endinterface

// File: rtl/systolic_feeder.sv
// systolic_feeder: holds 4x4 operands A/B and feeds them diagonally skewed into a 4x4 systolic array
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : systolic_feeder_if.slave (write port, start, status, edge streams)
module systolic_feeder #(
  parameter int DATA_W = 32
) (
  input logic              clk_i,
  input logic              rst_ni,
  systolic_feeder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DONE} state_t;
  state_t            r_state;
  logic [3:0]        r_t;
  logic              r_busy, r_clr_n, r_done;
  logic [DATA_W-1:0] r_a [4][4];
  logic [DATA_W-1:0] r_b [4][4];
  logic [DATA_W-1:0] r_left [4];
  logic [DATA_W-1:0] r_up [4];
  logic [DATA_W-1:0] w_left [4];
  logic [DATA_W-1:0] w_up [4];
  logic [3:0]        w_t_nxt;
  // Streams are registered, so they are computed for the step about to be shown;
  // step 10 (after t=9) falls outside every lane's window and yields all zeros.
  assign w_t_nxt = (r_state == CLEAR) ? 4'd0 : r_t + 4'd1;
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_left[i] = (w_t_nxt >= 4'(i) && w_t_nxt - 4'(i) <= 4'd3) ? r_a[i][2'(w_t_nxt - 4'(i))] : '0;
      w_up[i]   = (w_t_nxt >= 4'(i) && w_t_nxt - 4'(i) <= 4'd3) ? r_b[2'(w_t_nxt - 4'(i))][i] : '0;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_t     <= '0;
      r_busy  <= 1'b0;
      r_clr_n <= 1'b1;
      r_done  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_left[i] <= '0;
        r_up[i]   <= '0;
        for (int j = 0; j < 4; j++) begin
          r_a[i][j] <= '0;
          r_b[i][j] <= '0;
        end
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.wr_en_i && !bus.wr_sel_i) r_a[bus.wr_addr_i[3:2]][bus.wr_addr_i[1:0]] <= bus.wr_data_i;
          if (bus.wr_en_i && bus.wr_sel_i) r_b[bus.wr_addr_i[3:2]][bus.wr_addr_i[1:0]] <= bus.wr_data_i;
          if (bus.start_i) begin
            r_state <= CLEAR;
            r_busy  <= 1'b1;
            r_clr_n <= 1'b0;
          end
        end
        CLEAR: begin
          r_state <= STREAM;
          r_t     <= '0;
          r_clr_n <= 1'b1;
          r_left  <= w_left;
          r_up    <= w_up;
        end
        STREAM: begin
          r_left <= w_left;
          r_up   <= w_up;
          if (r_t == 4'd9) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_t <= r_t + 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
  assign bus.busy_o       = r_busy;
  assign bus.array_clr_no = r_clr_n;
  assign bus.done_o       = r_done;
  assign bus.left_o_0     = r_left[0];
  assign bus.left_o_1     = r_left[1];
  assign bus.left_o_2     = r_left[2];
  assign bus.left_o_3     = r_left[3];
  assign bus.up_o_0       = r_up[0];
  assign bus.up_o_1       = r_up[1];
  assign bus.up_o_2       = r_up[2];
  assign bus.up_o_3       = r_up[3];
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed, table-driven bench for systolic_feeder
module tb_systolic_feeder;
  localparam int DW = 32;
  localparam int KL = 0, KU = 1, KC = 2, KD = 3, KB = 4;
  typedef struct { int run; int kind; int lane; int cyc; logic [DW-1:0] exp; } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  systolic_feeder_if #(.DATA_W(DW)) bus ();
  systolic_feeder #(.DATA_W(DW)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  logic [DW-1:0] ma [4][4];
  logic [DW-1:0] mb [4][4];
  logic [DW-1:0] cl [14][4];
  logic [DW-1:0] cu [14][4];
  logic cb [14];
  logic cc [14];
  logic cd [14];
  vec_t tab [28];
  int vecs = 0;
  int errs = 0;
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic grab(input int c);
    cl[c][0] = bus.left_o_0; cl[c][1] = bus.left_o_1; cl[c][2] = bus.left_o_2; cl[c][3] = bus.left_o_3;
    cu[c][0] = bus.up_o_0;   cu[c][1] = bus.up_o_1;   cu[c][2] = bus.up_o_2;   cu[c][3] = bus.up_o_3;
    cb[c] = bus.busy_o;
    cc[c] = bus.array_clr_no;
    cd[c] = bus.done_o;
  endtask
  task automatic wr(input logic sel, input int r, input int c, input logic [DW-1:0] d);
    bus.wr_en_i = 1'b1;
    bus.wr_sel_i = sel;
    bus.wr_addr_i = 4'(r * 4 + c);
    bus.wr_data_i = d;
    @(negedge clk);
    bus.wr_en_i = 1'b0;
    if (sel) mb[r][c] = d; else ma[r][c] = d;
  endtask
  // Called just after a negedge in IDLE; start is sampled at the next edge (E0).
  // Captures cycles 1..13; at cycle 'poke' a write of A[0][0]=DEAD and a start pulse are driven.
  task automatic run_seq(input int poke);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.wr_en_i = 1'b0;
    for (int c = 1; c < 14; c++) begin
      if (c > 1) @(negedge clk);
      grab(c);
      if (c == poke) begin
        bus.wr_en_i = 1'b1; bus.wr_sel_i = 1'b0; bus.wr_addr_i = 4'd0; bus.wr_data_i = 32'hDEAD; bus.start_i = 1'b1;
      end else if (c == poke + 1) begin
        bus.wr_en_i = 1'b0; bus.start_i = 1'b0;
      end
    end
  endtask
  task automatic chk_model(input string nm);
    logic [DW-1:0] e;
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 4; i++) begin
        e = (t - i >= 0 && t - i <= 3) ? ma[i][t - i] : '0;
        chk($sformatf("%s left%0d t%0d", nm, i, t), cl[t + 2][i], e);
        e = (t - i >= 0 && t - i <= 3) ? mb[t - i][i] : '0;
        chk($sformatf("%s up%0d t%0d", nm, i, t), cu[t + 2][i], e);
      end
    end
    for (int c = 1; c < 14; c++) begin
      chk($sformatf("%s busy c%0d", nm, c), 32'(cb[c]), 32'(c <= 12));
      chk($sformatf("%s clr_n c%0d", nm, c), 32'(cc[c]), 32'(c != 1));
      chk($sformatf("%s done c%0d", nm, c), 32'(cd[c]), 32'(c == 12));
    end
  endtask
  task automatic check_tab(input int run);
    logic [DW-1:0] act;
    for (int k = 0; k < 28; k++) begin
      if (tab[k].run == run) begin
        case (tab[k].kind)
          KL: act = cl[tab[k].cyc][tab[k].lane];
          KU: act = cu[tab[k].cyc][tab[k].lane];
          KC: act = 32'(cc[tab[k].cyc]);
          KD: act = 32'(cd[tab[k].cyc]);
          default: act = 32'(cb[tab[k].cyc]);
        endcase
        chk($sformatf("tab run%0d k%0d kind%0d lane%0d cyc%0d", run, k, tab[k].kind, tab[k].lane, tab[k].cyc), act, tab[k].exp);
      end
    end
  endtask
  initial begin
    int d1, d2, lowc;
    // cycle = t + 2 for stream entries; control entries give the cycle directly
    tab = '{
      '{0, KC, 0, 1, 0},        '{0, KC, 0, 2, 1},        '{0, KL, 0, 2, 1},        '{0, KL, 0, 3, 0},
      '{0, KL, 3, 8, 1},        '{0, KL, 3, 7, 0},        '{0, KU, 0, 2, 1},        '{0, KU, 0, 3, 5},
      '{0, KU, 0, 4, 9},        '{0, KU, 0, 5, 13},       '{0, KU, 3, 5, 4},        '{0, KU, 3, 6, 8},
      '{0, KU, 3, 7, 12},       '{0, KU, 3, 8, 16},       '{0, KU, 3, 4, 0},        '{0, KD, 0, 11, 0},
      '{0, KD, 0, 12, 1},       '{0, KB, 0, 12, 1},       '{0, KB, 0, 13, 0},       '{0, KB, 0, 1, 1},
      '{1, KL, 2, 3, 0},        '{1, KL, 2, 4, 'h108},    '{1, KL, 2, 7, 'h10B},    '{1, KL, 2, 8, 0},
      '{1, KL, 0, 2, 'h100},    '{1, KL, 3, 8, 'h10F},    '{1, KL, 3, 9, 0},        '{1, KU, 3, 11, 0}
    };
    bus.wr_en_i = 1'b0; bus.wr_sel_i = 1'b0; bus.wr_addr_i = '0; bus.wr_data_i = '0; bus.start_i = 1'b0;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin ma[r][c] = '0; mb[r][c] = '0; end
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(bus.busy_o), 0);
    chk("reset clr_n", 32'(bus.array_clr_no), 1);
    chk("reset done", 32'(bus.done_o), 0);
    chk("reset left0", bus.left_o_0, 0);
    chk("reset up3", bus.up_o_3, 0);
    rst_n = 1'b1;
    @(negedge clk);
    // identity feed
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
      wr(1'b0, r, c, 32'(r == c));
      wr(1'b1, r, c, 32'(4 * r + c + 1));
    end
    run_seq(-1);
    check_tab(0);
    chk_model("ident");
    // skew boundaries
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) wr(1'b0, r, c, 32'h100 + 32'(4 * r + c));
    run_seq(-1);
    check_tab(1);
    chk_model("skew");
    // write + start during STREAM (t=4) must be ignored
    run_seq(6);
    chk_model("busyprot");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("no relaunch busy %0d", k), 32'(bus.busy_o), 0);
    end
    run_seq(-1);
    chk("busyprot old A00", cl[2][0], 32'h100);
    chk_model("busyprot2");
    // same-edge write and start
    bus.wr_en_i = 1'b1; bus.wr_sel_i = 1'b1; bus.wr_addr_i = 4'd0; bus.wr_data_i = 32'h55;
    mb[0][0] = 32'h55;
    run_seq(-1);
    chk("same-edge up0 t0", cu[2][0], 32'h55);
    chk_model("sameedge");
    // back-to-back with start held high
    d1 = -1; d2 = -1; lowc = 0;
    bus.start_i = 1'b1;
    for (int c = 1; c <= 40 && d2 < 0; c++) begin
      @(negedge clk);
      if (bus.done_o) begin
        if (d1 < 0) d1 = c; else d2 = c;
      end else if (d1 >= 0 && !bus.busy_o) lowc++;
    end
    bus.start_i = 1'b0;
    chk("b2b first done", 32'(d1), 32'd12);
    chk("b2b done spacing", 32'(d2 - d1), 32'd13);
    chk("b2b busy gap", 32'(lowc), 32'd1);
    for (int k = 0; k < 20 && bus.busy_o; k++) @(negedge clk);
    chk("b2b idle", 32'(bus.busy_o), 0);
    @(negedge clk);
    // reset mid-STREAM at t=4
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre-reset left3 t4", bus.left_o_3, 32'h10D);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(bus.busy_o), 0);
    chk("midrst clr_n", 32'(bus.array_clr_no), 1);
    chk("midrst done", 32'(bus.done_o), 0);
    chk("midrst left3", bus.left_o_3, 0);
    chk("midrst up1", bus.up_o_1, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      chk($sformatf("no done after reset %0d", k), 32'(bus.done_o), 0);
    end
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin ma[r][c] = '0; mb[r][c] = '0; end
    run_seq(-1);
    chk_model("zeroed");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
